axi_sram_responder: RTL and testbench
=====================================

Name: axi_sram_responder

Overview:
- AXI4 subordinate (responder) that terminates the LSU's AXI master port with a word-addressed, byte-strobed on-chip memory.
- Accepts single-beat writes and INCR read bursts, then returns R/B responses after a programmable access latency.
- Used as the data-memory model and as the DUT-side endpoint for LSU bring-up.

Parameters:
- ADDR_BASE, 32'h8000_0000, byte address of word 0
- DEPTH_LOG2, 12, memory depth is 2^DEPTH_LOG2 32-bit words
- LATENCY, 2, cycles from address (AR) or write-complete handshake to RVALID/BVALID; legal range 1..15

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- S_AXI_AWADDR in 32; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1; S_AXI_AWLEN in 8; S_AXI_AWSIZE in 3; S_AXI_AWBURST in 2; S_AXI_AWID in 4
- S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WLAST in 1; S_AXI_WVALID in 1; S_AXI_WREADY out 1
- S_AXI_BRESP out 2; S_AXI_BID out 4; S_AXI_BVALID out 1; S_AXI_BREADY in 1
- S_AXI_ARADDR in 32; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1; S_AXI_ARLEN in 8; S_AXI_ARSIZE in 3; S_AXI_ARBURST in 2; S_AXI_ARID in 4
- S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RID out 4; S_AXI_RLAST out 1; S_AXI_RVALID out 1; S_AXI_RREADY in 1

Behaviour:
- Reset (asynchronous): FSM to IDLE; all VALID/READY outputs, RDATA, RRESP, BRESP, RID, BID and RLAST are 0. Memory contents are not cleared.
  - Reset asserted mid-transaction abandons the transaction. Any partially received write is not committed.
- Ordering: one transaction in flight at a time.
- FSM states: IDLE, WR_COLLECT, WR_LAT, WR_RESP, RD_LAT, RD_RESP.
- IDLE:
  - AWREADY = WREADY = 1.
  - ARREADY = !AWVALID && !WVALID, so writes win simultaneous requests.
  - AW and W may handshake in the same cycle or in either order. Capture AWADDR, AWID and AWLEN, and the first W beat.
  - If both have handshaked (same cycle) and WLAST=1: go to WR_LAT. Otherwise go to WR_COLLECT.
- WR_COLLECT:
  - READY stays high only on the channel not yet received.
  - Further W beats (only possible when AWLEN!=0) are accepted and discarded until WLAST.
  - When both AW and the WLAST beat are done, go to WR_LAT.
- Write commit: on entry to WR_LAT, if status is OKAY, each byte lane i with WSTRB[i]=1 is written at word index (AWADDR-ADDR_BASE)>>2.
  - Data lanes are already address-aligned by the master; the responder applies no shifting.
- WR_LAT: count LATENCY-1 cycles, then assert BVALID with BID = captured AWID.
- WR_RESP: hold BVALID, BID and BRESP stable until BREADY; return to IDLE on the handshake.
  - The master raises BREADY only one cycle after seeing BVALID; the responder must wait.
- BRESP:
  - DECERR 2'b11 if the address is outside [ADDR_BASE, ADDR_BASE+4*2^DEPTH_LOG2).
  - Else SLVERR 2'b10 if AWLEN!=0 or AWBURST!=INCR/FIXED.
  - Else OKAY 2'b00.
  - Non-OKAY writes do not modify memory.
- Read accept: on the AR handshake, capture ARADDR, ARID and ARLEN; beat counter = 0; go to RD_LAT. Count LATENCY-1 cycles, then present beat 0 in RD_RESP.
- RD_RESP:
  - RVALID=1, RDATA = full 32-bit word at the current address, RID = ARID.
  - RLAST=1 when beat == ARLEN (ARLEN up to 255).
  - RVALID, RDATA, RRESP, RID and RLAST hold stable until RREADY.
  - On a handshake with RLAST: go to IDLE.
  - Otherwise advance the beat: INCR adds 4 to the address, FIXED keeps it, WRAP is treated as INCR.
  - The next beat appears the following cycle, with no extra latency.
- RRESP is per beat: DECERR if that beat's address is out of range (RDATA=0), else OKAY.
- Address low bits [1:0] are ignored for indexing. AxSIZE < 2 is legal; the full word is returned.
- Memory read is combinational from the registered address; RDATA is registered into the output on beat presentation.

Decomposition:
- Shared package axi_pkg holds:
  - RESP_OKAY/RESP_SLVERR/RESP_DECERR
  - BURST_FIXED/INCR/WRAP
  - the FSM state encoding
  - the AXI ID, LEN and STRB widths
- Sub-module sram_byte_we: 2^DEPTH_LOG2 x 32 array with a 4-bit byte write-enable and an asynchronous read port. The responder instantiates one.

Test Plan:
- Write then read: AW=0x8000_0010 and W=0xDEADBEEF/1111 in the same cycle, BREADY delayed 1 cycle → BVALID at LATENCY after the write completes, BRESP=00, BID echoed. A following AR to 0x8000_0010 → RDATA=0xDEADBEEF, RLAST=1, RRESP=00.
- Byte strobe: preload 0x11223344 at 0x8000_0020, write WDATA=0x0000AB00 with WSTRB=0010 → readback 0x1122AB44.
- W before AW: WVALID 3 cycles ahead of AWVALID (ID=4'h5) → both accepted, single commit, BID=5, no deadlock.
- Read burst: ARLEN=3, INCR from 0x8000_0000 over the words 0..3 with RREADY toggling 1,0,1,1,0,1 → 4 beats in order, each held while RREADY=0, RLAST only on beat 3.
- Errors: AR to 0x0000_0000 → RRESP=11, RDATA=0. AW with AWLEN=1 → both W beats accepted, BRESP=10, memory unchanged.
- Conflict/reset: AR and AW asserted in the same cycle → write accepted first, then the read. Assert reset during RD_LAT → RVALID=0 immediately, FSM in IDLE.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings, field widths and the responder FSM state type.
package axi_pkg;

    localparam int ID_W   = 4;
    localparam int LEN_W  = 8;
    localparam int STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_COLLECT,
        WR_LAT,
        WR_RESP,
        RD_LAT,
        RD_RESP
    } state_t;

endpackage

// File: rtl/sram_byte_we.sv
// Word-wide on-chip memory with per-byte write enables and an asynchronous read port.
module sram_byte_we #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clock,
    input  logic [3:0]            we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    // Each enabled byte lane updates only its own 8 bits of the addressed word.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4 responder: single-beat writes and INCR/FIXED read bursts into a byte-strobed SRAM,
// one transaction at a time, with a programmable response latency.
module axi_sram_responder
    import axi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       S_AXI_AWADDR,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [LEN_W-1:0]  S_AXI_AWLEN,
    input  logic [2:0]        S_AXI_AWSIZE,
    input  logic [1:0]        S_AXI_AWBURST,
    input  logic [ID_W-1:0]   S_AXI_AWID,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic [STRB_W-1:0] S_AXI_WSTRB,
    input  logic              S_AXI_WLAST,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic [ID_W-1:0]   S_AXI_BID,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [31:0]       S_AXI_ARADDR,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    input  logic [LEN_W-1:0]  S_AXI_ARLEN,
    input  logic [2:0]        S_AXI_ARSIZE,
    input  logic [1:0]        S_AXI_ARBURST,
    input  logic [ID_W-1:0]   S_AXI_ARID,
    output logic [31:0]       S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic [ID_W-1:0]   S_AXI_RID,
    output logic              S_AXI_RLAST,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY
);

    localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

    state_t state, next_state;

    logic [31:0]       aw_addr_q;
    logic [ID_W-1:0]   aw_id_q;
    logic [LEN_W-1:0]  aw_len_q;
    logic [1:0]        aw_burst_q;
    logic              aw_done;
    logic [31:0]       w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic              w_first;
    logic              w_done;
    logic [31:0]       rd_addr_q;
    logic [ID_W-1:0]   rd_id_q;
    logic [LEN_W-1:0]  rd_len_q;
    logic [1:0]        rd_burst_q;
    logic [LEN_W-1:0]  beat_q;
    logic [LEN_W-1:0]  beat_next;
    logic [3:0]        lat_cnt;
    logic              lat_done;
    logic              aw_hs, w_hs, ar_hs;
    logic              rd_advance, rd_present;
    logic [31:0]       wr_off, rd_look, rd_off, rd_next_addr;
    logic              wr_in_range, rd_in_range;
    logic [1:0]        wr_status;
    logic [STRB_W-1:0] mem_we;
    logic [31:0]       mem_rdata;
    logic              unused_bits;

    assign lat_done = (lat_cnt == LAT_LAST);
    assign aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs     = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;

    // Address decode for the captured write and the beat about to be presented.
    assign wr_off      = aw_addr_q - ADDR_BASE;
    assign wr_in_range = (aw_addr_q >= ADDR_BASE) && (wr_off[31:DEPTH_LOG2+2] == '0);
    assign rd_advance  = (state == RD_RESP) && S_AXI_RREADY && !S_AXI_RLAST;
    assign rd_present  = ((state == RD_LAT) && lat_done) || rd_advance;
    assign rd_look     = rd_advance ? rd_next_addr : rd_addr_q;
    assign beat_next   = rd_advance ? beat_q + 1'b1 : beat_q;
    assign rd_off      = rd_look - ADDR_BASE;
    assign rd_in_range = (rd_look >= ADDR_BASE) && (rd_off[31:DEPTH_LOG2+2] == '0);
    assign unused_bits = ^{S_AXI_AWSIZE, S_AXI_ARSIZE, wr_off[1:0], rd_off[1:0]};

    // Next burst address: FIXED repeats, WRAP is deliberately handled like INCR.
    always_comb begin
        rd_next_addr = rd_addr_q + 32'd4;
        case (rd_burst_q)
            BURST_FIXED: rd_next_addr = rd_addr_q;
            BURST_INCR,
            BURST_WRAP:  rd_next_addr = rd_addr_q + 32'd4;
            default:     rd_next_addr = rd_addr_q + 32'd4;
        endcase
    end

    // Write status: decode error dominates, then multi-beat or WRAP bursts are refused.
    always_comb begin
        wr_status = RESP_OKAY;
        if (!wr_in_range) begin
            wr_status = RESP_DECERR;
        end else if ((aw_len_q != '0) ||
                     !((aw_burst_q == BURST_INCR) || (aw_burst_q == BURST_FIXED))) begin
            wr_status = RESP_SLVERR;
        end
    end

    // Commit happens once, in the first WR_LAT cycle, from the captured first beat.
    assign mem_we = ((state == WR_LAT) && (lat_cnt == 4'd0) && (wr_status == RESP_OKAY))
                    ? w_strb_q : '0;

    sram_byte_we #(.DEPTH_LOG2(DEPTH_LOG2)) u_sram (
        .clock (clock),
        .we    (mem_we),
        .waddr (wr_off[DEPTH_LOG2+1:2]),
        .wdata (w_data_q),
        .raddr (rd_off[DEPTH_LOG2+1:2]),
        .rdata (mem_rdata)
    );

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and READY decode; READYs are forced low while reset is held.
    always_comb begin
        next_state    = state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_ARREADY = 1'b0;
        case (state)
            IDLE: begin
                S_AXI_AWREADY = !reset;
                S_AXI_WREADY  = !reset;
                S_AXI_ARREADY = !reset && !S_AXI_AWVALID && !S_AXI_WVALID;
                if (S_AXI_AWVALID || S_AXI_WVALID) begin
                    next_state = (S_AXI_AWVALID && S_AXI_WVALID && S_AXI_WLAST) ? WR_LAT : WR_COLLECT;
                end else if (S_AXI_ARVALID) begin
                    next_state = RD_LAT;
                end
            end
            WR_COLLECT: begin
                S_AXI_AWREADY = !reset && !aw_done;
                S_AXI_WREADY  = !reset && !w_done;
                if ((aw_done || S_AXI_AWVALID) && (w_done || (S_AXI_WVALID && S_AXI_WLAST))) begin
                    next_state = WR_LAT;
                end
            end
            WR_LAT:  if (lat_done) next_state = WR_RESP;
            WR_RESP: if (S_AXI_BREADY) next_state = IDLE;
            RD_LAT:  if (lat_done) next_state = RD_RESP;
            RD_RESP: if (S_AXI_RREADY && S_AXI_RLAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Channel capture, latency counting and registered B/R response outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aw_addr_q    <= '0;
            aw_id_q      <= '0;
            aw_len_q     <= '0;
            aw_burst_q   <= '0;
            aw_done      <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            w_first      <= 1'b0;
            w_done       <= 1'b0;
            rd_addr_q    <= '0;
            rd_id_q      <= '0;
            rd_len_q     <= '0;
            rd_burst_q   <= '0;
            beat_q       <= '0;
            lat_cnt      <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= '0;
            S_AXI_BID    <= '0;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= '0;
            S_AXI_RID    <= '0;
            S_AXI_RLAST  <= 1'b0;
        end else begin
            if (((state == WR_LAT) || (state == RD_LAT)) && !lat_done) lat_cnt <= lat_cnt + 4'd1;
            else                                                      lat_cnt <= '0;

            if (aw_hs) begin
                aw_addr_q  <= S_AXI_AWADDR;
                aw_id_q    <= S_AXI_AWID;
                aw_len_q   <= S_AXI_AWLEN;
                aw_burst_q <= S_AXI_AWBURST;
            end
            if (w_hs && ((state == IDLE) || !w_first)) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (state == IDLE) begin
                aw_done <= aw_hs;
                w_first <= w_hs;
                w_done  <= w_hs && S_AXI_WLAST;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs) begin
                    w_first <= 1'b1;
                    if (S_AXI_WLAST) w_done <= 1'b1;
                end
            end

            if (ar_hs) begin
                rd_addr_q  <= S_AXI_ARADDR;
                rd_id_q    <= S_AXI_ARID;
                rd_len_q   <= S_AXI_ARLEN;
                rd_burst_q <= S_AXI_ARBURST;
                beat_q     <= '0;
            end else if (rd_advance) begin
                rd_addr_q <= rd_next_addr;
                beat_q    <= beat_next;
            end

            if ((state == WR_LAT) && lat_done) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= wr_status;
                S_AXI_BID    <= aw_id_q;
            end else if ((state == WR_RESP) && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end

            if (rd_present) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_in_range ? mem_rdata : '0;
                S_AXI_RRESP  <= rd_in_range ? RESP_OKAY : RESP_DECERR;
                S_AXI_RID    <= rd_id_q;
                S_AXI_RLAST  <= (beat_next == rd_len_q);
            end else if ((state == RD_RESP) && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
                S_AXI_RLAST  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed self-checking bench for axi_sram_responder.
module tb_axi_sram_responder;

    localparam int LATENCY = 2;

    logic        clock, reset;
    logic [31:0] S_AXI_AWADDR;
    logic        S_AXI_AWVALID, S_AXI_AWREADY;
    logic [7:0]  S_AXI_AWLEN;
    logic [2:0]  S_AXI_AWSIZE;
    logic [1:0]  S_AXI_AWBURST;
    logic [3:0]  S_AXI_AWID;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic [3:0]  S_AXI_BID;
    logic        S_AXI_BVALID, S_AXI_BREADY;
    logic [31:0] S_AXI_ARADDR;
    logic        S_AXI_ARVALID, S_AXI_ARREADY;
    logic [7:0]  S_AXI_ARLEN;
    logic [2:0]  S_AXI_ARSIZE;
    logic [1:0]  S_AXI_ARBURST;
    logic [3:0]  S_AXI_ARID;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic [3:0]  S_AXI_RID;
    logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_data [16];
    logic [1:0]  exp_resp [16];

    axi_sram_responder #(
        .ADDR_BASE  (32'h8000_0000),
        .DEPTH_LOG2 (12),
        .LATENCY    (LATENCY)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_AWLEN   (S_AXI_AWLEN),
        .S_AXI_AWSIZE  (S_AXI_AWSIZE),
        .S_AXI_AWBURST (S_AXI_AWBURST),
        .S_AXI_AWID    (S_AXI_AWID),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WLAST   (S_AXI_WLAST),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BID     (S_AXI_BID),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_ARLEN   (S_AXI_ARLEN),
        .S_AXI_ARSIZE  (S_AXI_ARSIZE),
        .S_AXI_ARBURST (S_AXI_ARBURST),
        .S_AXI_ARID    (S_AXI_ARID),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RID     (S_AXI_RID),
        .S_AXI_RLAST   (S_AXI_RLAST),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for BVALID, checks latency/response/ID, holds BREADY low one extra cycle.
    task automatic wait_b(input logic [1:0] resp, input logic [3:0] id);
        int lat;
        lat = 0;
        while (!S_AXI_BVALID && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("b_latency", 32'(lat), 32'(LATENCY));
        check("b_resp", 32'(S_AXI_BRESP), 32'(resp));
        check("b_id", 32'(S_AXI_BID), 32'(id));
        @(negedge clock);
        check("b_hold_valid", 32'(S_AXI_BVALID), 32'd1);
        check("b_hold_resp", 32'(S_AXI_BRESP), 32'(resp));
        S_AXI_BREADY = 1'b1;
        @(negedge clock);
        S_AXI_BREADY = 1'b0;
        check("b_drop", 32'(S_AXI_BVALID), 32'd0);
    endtask

    // Single-beat write with AW and W presented together.
    task automatic write_single(input logic [31:0] addr, input logic [3:0] id,
                                input logic [31:0] data, input logic [3:0] strb,
                                input logic [1:0] resp);
        S_AXI_AWADDR = addr; S_AXI_AWID = id; S_AXI_AWLEN = 8'd0;
        S_AXI_AWBURST = 2'b01; S_AXI_AWSIZE = 3'd2; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WLAST = 1'b1; S_AXI_WVALID = 1'b1;
        @(negedge clock);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        wait_b(resp, id);
    endtask

    // Read burst checked beat by beat against exp_data/exp_resp, RREADY from rr_pat (LSB first).
    task automatic read_txn(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [15:0] rr_pat);
        int lat, beat, cyc;
        S_AXI_ARADDR = addr; S_AXI_ARID = id; S_AXI_ARLEN = len;
        S_AXI_ARBURST = 2'b01; S_AXI_ARSIZE = 3'd2; S_AXI_ARVALID = 1'b1;
        @(negedge clock);
        S_AXI_ARVALID = 1'b0;
        lat = 0;
        while (!S_AXI_RVALID && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("r_latency", 32'(lat), 32'(LATENCY));
        beat = 0;
        cyc = 0;
        while (beat <= int'(len) && cyc < 16) begin
            check("r_valid", 32'(S_AXI_RVALID), 32'd1);
            check("r_data", S_AXI_RDATA, exp_data[beat]);
            check("r_resp", 32'(S_AXI_RRESP), 32'(exp_resp[beat]));
            check("r_id", 32'(S_AXI_RID), 32'(id));
            check("r_last", 32'(S_AXI_RLAST), 32'(beat == int'(len)));
            S_AXI_RREADY = rr_pat[cyc];
            @(negedge clock);
            if (rr_pat[cyc]) beat++;
            cyc++;
        end
        S_AXI_RREADY = 1'b0;
        check("r_beats", 32'(beat), 32'(int'(len) + 1));
        check("r_idle", 32'(S_AXI_RVALID), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = '0;
        S_AXI_AWBURST = '0; S_AXI_AWID = '0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = '0;
        S_AXI_ARBURST = '0; S_AXI_ARID = '0; S_AXI_RREADY = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        check("rst_rdata", S_AXI_RDATA, 32'd0);
        check("rst_rlast", 32'(S_AXI_RLAST), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_awready", 32'(S_AXI_AWREADY), 32'd1);
        check("idle_arready", 32'(S_AXI_ARREADY), 32'd1);

        // Write then read back, same-cycle AW/W
        S_AXI_AWADDR = 32'h8000_0010; S_AXI_AWID = 4'h3; S_AXI_AWLEN = 8'd0;
        S_AXI_AWBURST = 2'b01; S_AXI_AWSIZE = 3'd2; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b1; S_AXI_WVALID = 1'b1;
        #1;
        check("t1_awready", 32'(S_AXI_AWREADY), 32'd1);
        check("t1_wready", 32'(S_AXI_WREADY), 32'd1);
        check("t1_arready_blocked", 32'(S_AXI_ARREADY), 32'd0);
        @(negedge clock);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        wait_b(2'b00, 4'h3);
        exp_data[0] = 32'hDEAD_BEEF; exp_resp[0] = 2'b00;
        read_txn(32'h8000_0010, 4'h7, 8'd0, 16'hFFFF);

        // Byte strobe merge
        write_single(32'h8000_0020, 4'h1, 32'h1122_3344, 4'hF, 2'b00);
        write_single(32'h8000_0020, 4'h2, 32'h0000_AB00, 4'b0010, 2'b00);
        exp_data[0] = 32'h1122_AB44; exp_resp[0] = 2'b00;
        read_txn(32'h8000_0020, 4'h2, 8'd0, 16'hFFFF);

        // W arrives three cycles before AW
        S_AXI_WDATA = 32'hCAFE_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b1; S_AXI_WVALID = 1'b1;
        @(negedge clock);
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        check("t3_wready_after_w", 32'(S_AXI_WREADY), 32'd0);
        check("t3_awready_wait", 32'(S_AXI_AWREADY), 32'd1);
        repeat (2) @(negedge clock);
        check("t3_no_early_b", 32'(S_AXI_BVALID), 32'd0);
        S_AXI_AWADDR = 32'h8000_0030; S_AXI_AWID = 4'h5; S_AXI_AWLEN = 8'd0;
        S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1'b1;
        @(negedge clock);
        S_AXI_AWVALID = 1'b0;
        wait_b(2'b00, 4'h5);
        exp_data[0] = 32'hCAFE_F00D; exp_resp[0] = 2'b00;
        read_txn(32'h8000_0030, 4'h5, 8'd0, 16'hFFFF);

        // INCR burst of 4 with RREADY 1,0,1,1,0,1
        for (int i = 0; i < 4; i++) begin
            write_single(32'h8000_0000 + 32'(4 * i), 4'h0, 32'hA0A0_0000 + 32'(i), 4'hF, 2'b00);
            exp_data[i] = 32'hA0A0_0000 + 32'(i);
            exp_resp[i] = 2'b00;
        end
        read_txn(32'h8000_0000, 4'hC, 8'd3, 16'h002D);

        // Out-of-range read
        exp_data[0] = 32'd0; exp_resp[0] = 2'b11;
        read_txn(32'h0000_0000, 4'h1, 8'd0, 16'hFFFF);

        // AWLEN=1 write: both beats accepted, SLVERR, memory untouched
        S_AXI_AWADDR = 32'h8000_0010; S_AXI_AWID = 4'h6; S_AXI_AWLEN = 8'd1;
        S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'hFFFF_FFFF; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b1;
        @(negedge clock);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'h1234_5678; S_AXI_WLAST = 1'b1;
        #1;
        check("t5_awready_done", 32'(S_AXI_AWREADY), 32'd0);
        check("t5_wready_beat1", 32'(S_AXI_WREADY), 32'd1);
        @(negedge clock);
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0; S_AXI_AWLEN = 8'd0;
        wait_b(2'b10, 4'h6);
        exp_data[0] = 32'hDEAD_BEEF; exp_resp[0] = 2'b00;
        read_txn(32'h8000_0010, 4'h6, 8'd0, 16'hFFFF);

        // Simultaneous AR and AW/W: write first, read sees the new data
        S_AXI_AWADDR = 32'h8000_0040; S_AXI_AWID = 4'h9; S_AXI_AWLEN = 8'd0;
        S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h55AA_55AA; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 32'h8000_0040; S_AXI_ARID = 4'h2; S_AXI_ARLEN = 8'd0;
        S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1;
        #1;
        check("t6_arready_conflict", 32'(S_AXI_ARREADY), 32'd0);
        @(negedge clock);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        check("t6_arready_busy", 32'(S_AXI_ARREADY), 32'd0);
        wait_b(2'b00, 4'h9);
        check("t6_arready_idle", 32'(S_AXI_ARREADY), 32'd1);
        @(negedge clock);
        S_AXI_ARVALID = 1'b0;
        begin
            int lat;
            lat = 0;
            while (!S_AXI_RVALID && lat < 20) begin
                @(negedge clock);
                lat++;
            end
            check("t6_r_latency", 32'(lat), 32'(LATENCY));
        end
        check("t6_rdata", S_AXI_RDATA, 32'h55AA_55AA);
        check("t6_rid", 32'(S_AXI_RID), 32'h2);
        S_AXI_RREADY = 1'b1;
        @(negedge clock);
        S_AXI_RREADY = 1'b0;
        check("t6_r_done", 32'(S_AXI_RVALID), 32'd0);

        // Reset asserted in the last RD_LAT cycle
        S_AXI_ARADDR = 32'h8000_0010; S_AXI_ARID = 4'h4; S_AXI_ARVALID = 1'b1;
        @(negedge clock);
        S_AXI_ARVALID = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("t7_rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        check("t7_rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        @(negedge clock);
        check("t7_rst_rvalid_held", 32'(S_AXI_RVALID), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("t7_idle_awready", 32'(S_AXI_AWREADY), 32'd1);
        check("t7_idle_arready", 32'(S_AXI_ARREADY), 32'd1);
        repeat (3) @(negedge clock);
        check("t7_rvalid_quiet", 32'(S_AXI_RVALID), 32'd0);
        exp_data[0] = 32'hDEAD_BEEF; exp_resp[0] = 2'b00;
        read_txn(32'h8000_0010, 4'h4, 8'd0, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
